dac_frame_scheduler: RTL and testbench

- Shares the single serial DAC transmitter (24-bit word in, 1-bit serial out) between up to NUM_SRC drum-voice sample sources.
- Generates the fixed DAC frame timing and round-robin arbitrates pending requesters at each frame boundary.
- Latches the winning 24-bit sample and holds it stable on dataAConvertir for the whole frame while the transmitter shifts it out.
- Sits between the drum voice players and the DAC transmitter in the audio path.

---
 rtl/dac_sched_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/dac_frame_scheduler.sv | 74 +++++++
 tb/tb_dac_frame_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dac_sched_pkg.sv
// dac_sched_pkg: shared defaults and round-robin helper for the DAC frame scheduler
package dac_sched_pkg;
   localparam int SAMPLE_W_DEF = 24;
   localparam int FRAME_CYCLES_DEF = 48;
   localparam logic [23:0] SILENCE_WORD = 24'h000000;
   function automatic int rr_next(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from one past the pointer
module rr_arbiter
   import dac_sched_pkg::*;
#(
   parameter int NUM_SRC = 4,
   localparam int IW = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IW-1:0]      pointer,
   input  logic               enable,
   output logic [NUM_SRC-1:0] grant,
   output logic [IW-1:0]      grant_idx,
   output logic               any_grant
);
   logic [IW-1:0] p;
   always_comb begin
      grant = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      p = IW'(rr_next(int'(pointer), NUM_SRC));
      for (int k = 0; k < NUM_SRC; k++) begin
         if (enable && !any_grant && req[p]) begin
            grant[p] = 1'b1;
            grant_idx = p;
            any_grant = 1'b1;
         end
         p = IW'(rr_next(int'(p), NUM_SRC));
      end
   end
endmodule

// File: rtl/dac_frame_scheduler.sv
// dac_frame_scheduler: frame timing, round-robin source selection and word capture for the DAC transmitter
// Define DAC_UNDERRUN_CNT_EN to add a saturating idle-frame counter with clear.
module dac_frame_scheduler
   import dac_sched_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int SAMPLE_W = SAMPLE_W_DEF,
   parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
   parameter int HOLD_ON_IDLE = 0,
   localparam int IW = $clog2(NUM_SRC),
   localparam int CW = $clog2(FRAME_CYCLES)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_SRC-1:0]          req,
   input  logic [NUM_SRC*SAMPLE_W-1:0] sample_in,
`ifdef DAC_UNDERRUN_CNT_EN
   input  logic                        underrun_clr,
   output logic [15:0]                 underrun_cnt,
`endif
   output logic [NUM_SRC-1:0]          ack,
   output logic [SAMPLE_W-1:0]         dataAConvertir,
   output logic                        frame_start,
   output logic [IW-1:0]               grant_idx,
   output logic                        frame_valid
);
   logic [CW-1:0] frame_cnt;
   logic [IW-1:0] pointer, win;
   logic boundary, any;
   logic [SAMPLE_W-1:0] smp [NUM_SRC];
   for (genvar s = 0; s < NUM_SRC; s++) begin : g_smp
      assign smp[s] = sample_in[s*SAMPLE_W +: SAMPLE_W];
   end
   assign boundary = frame_cnt == CW'(FRAME_CYCLES - 1);
   // ack is the arbiter grant itself, so a req rising in the boundary cycle still competes
   rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
      .req,
      .pointer,
      .enable(boundary),
      .grant(ack),
      .grant_idx(win),
      .any_grant(any)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_cnt <= '0;
         pointer <= IW'(NUM_SRC - 1);
         dataAConvertir <= '0;
         frame_start <= 1'b0;
         grant_idx <= '0;
         frame_valid <= 1'b0;
      end else begin
         frame_cnt <= boundary ? '0 : frame_cnt + 1'b1;
         frame_start <= boundary;
         if (boundary) begin
            frame_valid <= any;
            if (any) begin
               pointer <= win;
               grant_idx <= win;
               dataAConvertir <= smp[win];
            end else if (HOLD_ON_IDLE == 0) begin
               dataAConvertir <= SAMPLE_W'(SILENCE_WORD);
            end
         end
      end
   end
`ifdef DAC_UNDERRUN_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) underrun_cnt <= '0;
      else if (underrun_clr) underrun_cnt <= '0;
      else if (boundary && !any && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_dac_frame_scheduler.sv
// tb_dac_frame_scheduler: scoreboard bench for dac_frame_scheduler (silence and hold-on-idle instances)
module tb_dac_frame_scheduler;
   localparam int N = 4;
   localparam int SW = 24;
   localparam int FC = 48;
   typedef struct {
      logic [SW-1:0] data;
      logic [1:0]    idx;
      logic          valid;
      logic [SW-1:0] hdata;
   } exp_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;
   logic [N-1:0] req;
   logic [N*SW-1:0] sample_in;
   logic [N-1:0] ack, ack_h;
   logic [SW-1:0] dac, dac_h;
   logic fs, fs_h, fv, fv_h;
   logic [1:0] gi, gi_h;
`ifdef DAC_UNDERRUN_CNT_EN
   logic clr;
   logic [15:0] urc, urc_h, exp_urc, u0;
`endif
   exp_t sb[$];
   exp_t cur;
   int cnt, ptr, last_idx, tests, fails;
   logic [SW-1:0] hword;
   bit hold_req;

   dac_frame_scheduler #(.NUM_SRC(N), .HOLD_ON_IDLE(0)) u_dut (
      .clk(clk), .reset(reset), .req(req), .sample_in(sample_in),
`ifdef DAC_UNDERRUN_CNT_EN
      .underrun_clr(clr), .underrun_cnt(urc),
`endif
      .ack(ack), .dataAConvertir(dac), .frame_start(fs), .grant_idx(gi), .frame_valid(fv)
   );
   dac_frame_scheduler #(.NUM_SRC(N), .HOLD_ON_IDLE(1)) u_hold (
      .clk(clk), .reset(reset), .req(req), .sample_in(sample_in),
`ifdef DAC_UNDERRUN_CNT_EN
      .underrun_clr(clr), .underrun_cnt(urc_h),
`endif
      .ack(ack_h), .dataAConvertir(dac_h), .frame_start(fs_h), .grant_idx(gi_h), .frame_valid(fv_h)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic int model_win(input logic [N-1:0] r, input int p);
      for (int k = 1; k <= N; k++)
         if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic step();
      exp_t e;
      logic [N-1:0] ea;
      int w;
      ea = '0;
      w = -1;
      #1;
      if (cnt == FC - 1) begin
         w = model_win(req, ptr);
         e.valid = (w >= 0);
         if (w >= 0) begin
            ea[w] = 1'b1;
            ptr = w;
            last_idx = w;
            hword = sample_in[w*SW +: SW];
         end
         e.data = (w >= 0) ? hword : '0;
         e.idx = 2'(last_idx);
         e.hdata = hword;
         sb.push_back(e);
      end
      chk("ack", ack, ea);
      chk("ack_hold", ack_h, ea);
`ifdef DAC_UNDERRUN_CNT_EN
      if (clr) exp_urc = '0;
      else if (cnt == FC - 1 && w < 0 && exp_urc != 16'hFFFF) exp_urc = exp_urc + 16'd1;
`endif
      @(posedge clk);
      cnt = (cnt == FC - 1) ? 0 : cnt + 1;
      @(negedge clk);
      if (!hold_req) req = req & ~ea;
      chk("frame_start", fs, cnt == 0);
      chk("frame_start_hold", fs_h, cnt == 0);
      if (cnt == 0) begin
         chk("scoreboard_nonempty", 32'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk("data", dac, cur.data);
            chk("grant_idx", gi, cur.idx);
            chk("frame_valid", fv, cur.valid);
            chk("data_hold", dac_h, cur.hdata);
            chk("grant_idx_hold", gi_h, cur.idx);
            chk("frame_valid_hold", fv_h, cur.valid);
`ifdef DAC_UNDERRUN_CNT_EN
            chk("underrun_cnt", urc, exp_urc);
            chk("underrun_cnt_hold", urc_h, exp_urc);
`endif
         end
      end else if (cnt == FC / 2) begin
         chk("data_stable", dac, cur.data);
         chk("data_stable_hold", dac_h, cur.hdata);
      end
   endtask

   task automatic run_to(input int c);
      do step(); while (cnt != c);
   endtask

   task automatic model_reset();
      cnt = 0;
      ptr = N - 1;
      last_idx = 0;
      hword = '0;
      sb.delete();
      cur.data = '0;
      cur.hdata = '0;
      cur.idx = '0;
      cur.valid = 1'b0;
`ifdef DAC_UNDERRUN_CNT_EN
      exp_urc = '0;
`endif
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_data"}, dac, 0);
      chk({tag, "_data_hold"}, dac_h, 0);
      chk({tag, "_valid"}, fv, 0);
      chk({tag, "_idx"}, gi, 0);
      chk({tag, "_fs"}, fs, 0);
      chk({tag, "_ack"}, ack, 0);
`ifdef DAC_UNDERRUN_CNT_EN
      chk({tag, "_urc"}, urc, 0);
`endif
   endtask

   initial begin
      tests = 0;
      fails = 0;
      hold_req = 0;
      reset = 1'b0;
      req = '0;
      sample_in = '0;
`ifdef DAC_UNDERRUN_CNT_EN
      clr = 1'b0;
`endif
      model_reset();
      repeat (3) @(negedge clk);
      chk_zero("reset");
      reset = 1'b1;
      repeat (3 * FC) step();
      sample_in[0 +: SW] = 24'd101;
      req = 4'b0001;
      run_to(FC - 1);
      run_to(1);
      chk("single_data", dac, 101);
      chk("single_idx", gi, 0);
      chk("single_valid", fv, 1);
      run_to(20);
      reset = 1'b0;
      #1;
      chk_zero("midreset");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (FC) step();
      for (int i = 0; i < N; i++) sample_in[i*SW +: SW] = 24'h800000 + 24'(i);
      req = 4'b1111;
      hold_req = 1;
      for (int k = 0; k < 5; k++) begin
         run_to(FC - 1);
         run_to(1);
         chk("rr_idx", gi, k % N);
         chk("rr_data", dac, 24'h800000 + 24'(k % N));
      end
      hold_req = 0;
      req = 4'b0010;
      run_to(FC - 1);
      req = 4'b0110;
      run_to(1);
      chk("late_req_first", gi, 1);
      run_to(FC - 1);
      run_to(1);
      chk("late_req_second", gi, 2);
      run_to(FC - 1);
      req = 4'b1000;
      run_to(1);
      chk("boundary_rise_alone", gi, 3);
      chk("boundary_rise_data", dac, 24'h800003);
`ifdef DAC_UNDERRUN_CNT_EN
      u0 = exp_urc;
      repeat (5) begin
         run_to(FC - 1);
         run_to(1);
      end
      chk("underrun_plus5", urc, 32'(u0) + 5);
      run_to(FC - 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("underrun_cleared", urc, 0);
      run_to(1);
`else
      repeat (2) begin
         run_to(FC - 1);
         run_to(1);
      end
`endif
      chk("idle_hold_word", dac_h, 24'h800003);
      chk("idle_silence", dac, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
